// File: rtl/fp_add_arbiter_if.sv
// Bundle of the requester, adder and response channels of fp_add_arbiter.
// slave: the arbiter side. master: the requesters, adder and response consumer.
interface fp_add_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
);
    logic [NUM_REQ-1:0]    req_valid;
    logic [NUM_REQ-1:0]    req_ready;
    logic [64*NUM_REQ-1:0] req_a;
    logic [64*NUM_REQ-1:0] req_b;
    logic [63:0]           fpu_a;
    logic [63:0]           fpu_b;
    logic [63:0]           fpu_sum;
    logic                  resp_valid;
    logic                  resp_ready;
    logic [ID_W-1:0]       resp_id;
    logic [63:0]           resp_data;
    logic                  busy;

    modport slave (
        input  req_valid, req_a, req_b, fpu_sum, resp_ready,
        output req_ready, fpu_a, fpu_b, resp_valid, resp_id, resp_data, busy
    );

    modport master (
        output req_valid, req_a, req_b, fpu_sum, resp_ready,
        input  req_ready, fpu_a, fpu_b, resp_valid, resp_id, resp_data, busy
    );
endinterface

// File: rtl/fp_add_arbiter.sv
// Round-robin arbiter sharing one combinational double-precision adder among
// NUM_REQ requesters. The winner's operands are registered, held for
// SETTLE_CYC cycles, then the sum is sampled and returned on a valid/ready
// response channel tagged with the requester index.
// Optional macro FP_ADD_ARB_STATS_EN adds op_count / stall_count outputs.
module fp_add_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int ID_W       = 2,
    parameter int SETTLE_CYC = 2
) (
    input  logic        clk,
    input  logic        rst,
`ifdef FP_ADD_ARB_STATS_EN
    output logic [31:0] op_count,
    output logic [31:0] stall_count,
`endif
    fp_add_arbiter_if.slave bus
);
    localparam int CNT_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SETTLE = 2'd1;
    localparam logic [1:0] ST_RESP   = 2'd2;

    logic [1:0]         state_reg;
    logic [ID_W-1:0]    rr_ptr_reg;
    logic [ID_W-1:0]    id_reg;
    logic [CNT_W-1:0]   cnt_reg;
    logic [63:0]        fpu_a_reg;
    logic [63:0]        fpu_b_reg;
    logic [63:0]        resp_data_reg;
    logic [ID_W-1:0]    resp_id_reg;
    logic               resp_valid_reg;

    logic               grant_found;
    logic [ID_W-1:0]    grant_idx;
    logic [ID_W-1:0]    ptr_next;
    logic [NUM_REQ-1:0] grant_onehot;
    int                 scan_idx;

    // Per-requester operand views unpacked from the flat buses.
    logic [63:0] a_arr [NUM_REQ];
    logic [63:0] b_arr [NUM_REQ];

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
            assign a_arr[gi] = bus.req_a[64*gi +: 64];
            assign b_arr[gi] = bus.req_b[64*gi +: 64];
        end
    endgenerate

    // Round-robin search: first valid requester at or after rr_ptr, wrapping.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        scan_idx    = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            scan_idx = int'(rr_ptr_reg) + k;
            if (scan_idx >= NUM_REQ) begin
                scan_idx = scan_idx - NUM_REQ;
            end
            if (!grant_found && bus.req_valid[scan_idx]) begin
                grant_found = 1'b1;
                grant_idx   = ID_W'(scan_idx);
            end
        end
    end

    assign ptr_next     = (grant_idx == ID_W'(NUM_REQ - 1)) ? '0 : grant_idx + ID_W'(1);
    assign grant_onehot = NUM_REQ'(1) << grant_idx;

    // Grants are only offered while idle; the handshake completes in that cycle.
    assign bus.req_ready  = (state_reg == ST_IDLE && grant_found) ? grant_onehot : '0;
    assign bus.fpu_a      = fpu_a_reg;
    assign bus.fpu_b      = fpu_b_reg;
    assign bus.resp_valid = resp_valid_reg;
    assign bus.resp_id    = resp_id_reg;
    assign bus.resp_data  = resp_data_reg;
    assign bus.busy       = (state_reg != ST_IDLE);

    // Control FSM: accept, let the adder settle, then hold the response.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= ST_IDLE;
            rr_ptr_reg     <= '0;
            id_reg         <= '0;
            cnt_reg        <= '0;
            fpu_a_reg      <= '0;
            fpu_b_reg      <= '0;
            resp_data_reg  <= '0;
            resp_id_reg    <= '0;
            resp_valid_reg <= 1'b0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (grant_found) begin
                        fpu_a_reg  <= a_arr[grant_idx];
                        fpu_b_reg  <= b_arr[grant_idx];
                        id_reg     <= grant_idx;
                        rr_ptr_reg <= ptr_next;
                        cnt_reg    <= CNT_W'(SETTLE_CYC - 1);
                        state_reg  <= ST_SETTLE;
                    end
                end
                ST_SETTLE: begin
                    if (cnt_reg == '0) begin
                        resp_data_reg  <= bus.fpu_sum;
                        resp_id_reg    <= id_reg;
                        resp_valid_reg <= 1'b1;
                        state_reg      <= ST_RESP;
                    end else begin
                        cnt_reg <= cnt_reg - CNT_W'(1);
                    end
                end
                ST_RESP: begin
                    if (bus.resp_ready) begin
                        resp_valid_reg <= 1'b0;
                        state_reg      <= ST_IDLE;
                    end
                end
                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

`ifdef FP_ADD_ARB_STATS_EN
    logic [31:0] op_count_reg;
    logic [31:0] stall_count_reg;

    assign op_count    = op_count_reg;
    assign stall_count = stall_count_reg;

    // Count completed responses and cycles the consumer stalls a response.
    always_ff @(posedge clk) begin
        if (rst) begin
            op_count_reg    <= '0;
            stall_count_reg <= '0;
        end else if (state_reg == ST_RESP) begin
            if (bus.resp_ready) begin
                op_count_reg <= op_count_reg + 32'd1;
            end else begin
                stall_count_reg <= stall_count_reg + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_fp_add_arbiter.sv
// Self-checking bench for fp_add_arbiter: directed scenarios plus random
// traffic, checked against a transaction-level model and a response scoreboard.
module tb_fp_add_arbiter;
    localparam int N  = 4;
    localparam int IDW = 2;
    localparam int S  = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
`ifdef FP_ADD_ARB_STATS_EN
    logic [31:0] op_count;
    logic [31:0] stall_count;
`endif

    fp_add_arbiter_if #(.NUM_REQ(N), .ID_W(IDW)) bus ();

    fp_add_arbiter #(.NUM_REQ(N), .ID_W(IDW), .SETTLE_CYC(S)) dut (
        .clk        (clk),
        .rst        (rst),
`ifdef FP_ADD_ARB_STATS_EN
        .op_count   (op_count),
        .stall_count(stall_count),
`endif
        .bus        (bus.slave)
    );

    always #5 clk = ~clk;

    // Behavioural double-precision adder standing in for the shared datapath.
    assign bus.fpu_sum = $realtobits($bitstoreal(bus.fpu_a) + $bitstoreal(bus.fpu_b));

    typedef struct {
        int          id;
        logic [63:0] data;
    } exp_t;

    exp_t sb[$];

    int n_checks = 0;
    int n_pass   = 0;

    // Stimulus for the next cycle.
    logic [N-1:0] drv_valid = '0;
    logic [63:0]  drv_a [N];
    logic [63:0]  drv_b [N];
    logic         drv_rr  = 1'b1;
    logic         drv_rst = 1'b1;

    // Transaction-level model.
    int          cyc = 0;
    bit          m_busy = 0;
    int          m_ready_cyc = 0;
    int          m_ptr = 0;
    int          m_win = -1;
    logic [63:0] m_a = '0;
    logic [63:0] m_b = '0;
    int          m_ops = 0;
    int          m_stalls = 0;

    // Values observed by the monitor.
    logic [63:0] last_data = '0;
    int          last_id = -1;
    logic [63:0] resp_by_id [N];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [63:0] rand_op();
        return $realtobits((real'($urandom_range(0, 4000)) - 2000.0) / 16.0);
    endfunction

    // One clock cycle: drive, compare against the model, advance the model.
    task automatic cycle();
        logic [N-1:0] exp_ready;
        bit           in_resp;
        @(negedge clk);
        rst = drv_rst;
        bus.req_valid  = drv_valid;
        bus.resp_ready = drv_rr;
        for (int i = 0; i < N; i++) begin
            bus.req_a[64*i +: 64] = drv_a[i];
            bus.req_b[64*i +: 64] = drv_b[i];
        end
        #1;
        m_win = -1;
        in_resp = m_busy && (cyc >= m_ready_cyc);
        if (!drv_rst) begin
            exp_ready = '0;
            if (!m_busy) begin
                for (int k = 0; k < N; k++) begin
                    if (m_win < 0 && drv_valid[(m_ptr + k) % N]) m_win = (m_ptr + k) % N;
                end
            end
            if (m_win >= 0) exp_ready[m_win] = 1'b1;
            check("req_ready", 64'(bus.req_ready), 64'(exp_ready));
            check("resp_valid", 64'(bus.resp_valid), 64'(in_resp));
            check("busy", 64'(bus.busy), 64'(m_busy));
            check("fpu_a", bus.fpu_a, m_a);
            check("fpu_b", bus.fpu_b, m_b);
`ifdef FP_ADD_ARB_STATS_EN
            check("op_count", 64'(op_count), 64'(m_ops));
            check("stall_count", 64'(stall_count), 64'(m_stalls));
`endif
        end
        @(posedge clk);
        if (drv_rst) begin
            m_busy = 0; m_ptr = 0; m_a = '0; m_b = '0;
            m_ops = 0; m_stalls = 0;
            sb.delete();
        end else begin
            if (in_resp) begin
                if (drv_rr) begin
                    m_busy = 0;
                    m_ops++;
                end else begin
                    m_stalls++;
                end
            end
            if (m_win >= 0) begin
                exp_t e;
                e.id   = m_win;
                e.data = $realtobits($bitstoreal(drv_a[m_win]) + $bitstoreal(drv_b[m_win]));
                sb.push_back(e);
                m_busy      = 1;
                m_ready_cyc = cyc + S + 1;
                m_ptr       = (m_win + 1) % N;
                m_a         = drv_a[m_win];
                m_b         = drv_b[m_win];
            end
        end
        cyc++;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic do_reset();
        drv_rst = 1'b1; drv_valid = '0;
        run(2);
        drv_rst = 1'b0;
    endtask

    // Monitor: pops the scoreboard on every response handshake.
    initial begin
        bit          hold_prev;
        logic [63:0] prev_data;
        logic [IDW-1:0] prev_id;
        hold_prev = 0;
        prev_data = '0;
        prev_id   = '0;
        forever begin
            @(negedge clk);
            #2;
            if (rst) begin
                hold_prev = 0;
            end else begin
                if (hold_prev && bus.resp_valid) begin
                    check("resp_data_hold", bus.resp_data, prev_data);
                    check("resp_id_hold", 64'(bus.resp_id), 64'(prev_id));
                end
                if (bus.resp_valid && bus.resp_ready) begin
                    if (sb.size() == 0) begin
                        check("resp_unexpected", 64'(bus.resp_valid), 64'd0);
                    end else begin
                        exp_t e;
                        e = sb.pop_front();
                        check("resp_id", 64'(bus.resp_id), 64'(e.id));
                        check("resp_data", bus.resp_data, e.data);
                        $display("resp id=%0d data=%h", bus.resp_id, bus.resp_data);
                        last_data = bus.resp_data;
                        last_id   = int'(bus.resp_id);
                        resp_by_id[bus.resp_id] = bus.resp_data;
                    end
                end
                hold_prev = bus.resp_valid && !bus.resp_ready;
                prev_data = bus.resp_data;
                prev_id   = bus.resp_id;
            end
        end
    end

    initial begin
        for (int i = 0; i < N; i++) begin
            drv_a[i] = $realtobits(real'(i + 1));
            drv_b[i] = $realtobits(0.5);
            resp_by_id[i] = '0;
        end
        bus.req_valid  = '0;
        bus.resp_ready = 1'b1;
        bus.req_a      = '0;
        bus.req_b      = '0;

        // Reset state.
        do_reset();
        run(1);
        check("reset_resp_data", bus.resp_data, 64'd0);
        check("reset_resp_id", 64'(bus.resp_id), 64'd0);

        // Single op: 1.0 + 1.0 from requester 0.
        drv_a[0] = 64'h3FF0000000000000;
        drv_b[0] = 64'h3FF0000000000000;
        drv_valid = 4'b0001; drv_rr = 1'b1;
        run(1);
        drv_valid = '0;
        run(5);
        check("single_data", last_data, 64'h4000000000000000);
        check("single_id", 64'(last_id), 64'd0);

        // All four requesting continuously from a fresh pointer.
        do_reset();
        drv_a[2] = 64'h3FF8000000000000;
        drv_b[2] = 64'hC008000000000000;
        drv_valid = 4'b1111;
        run(5 * (S + 2));
        drv_valid = '0;
        run(6);
        check("rr_req2_data", resp_by_id[2], 64'hBFF8000000000000);

        // Backpressure with an early-dropped request from requester 1.
        do_reset();
        drv_valid = 4'b0001; drv_rr = 1'b0;
        run(1);
        drv_valid = '0;
        run(3);
        drv_valid = 4'b0010;
        run(2);
        drv_valid = '0;
        run(2);
        drv_rr = 1'b1;
        run(1);
`ifdef FP_ADD_ARB_STATS_EN
        #1;
        check("stats_stall", 64'(stall_count), 64'd5);
        check("stats_ops", 64'(op_count), 64'd1);
`endif
        run(3);

        // Reset while the adder is settling, then serve requester 1.
        drv_valid = 4'b0010;
        run(1);
        drv_valid = '0;
        run(1);
        drv_rst = 1'b1;
        run(1);
        drv_rst = 1'b0;
        run(1);
        check("midreset_busy", 64'(bus.busy), 64'd0);
        drv_valid = 4'b0010;
        run(1);
        drv_valid = '0;
        run(5);
        check("midreset_id", 64'(last_id), 64'd1);

        // Wrap: move pointer to 3, then requesters 0 and 3 compete.
        drv_valid = 4'b0100;
        run(1);
        drv_valid = '0;
        run(4);
        drv_valid = 4'b1001;
        run(2 * (S + 2));
        drv_valid = 4'b0011;
        run(1);
        drv_valid = '0;
        run(5);
        check("wrap_ptr_id", 64'(last_id), 64'd1);

        // Random traffic.
        for (int t = 0; t < 1500; t++) begin
            drv_valid = N'($urandom_range(0, (1 << N) - 1));
            if ($urandom_range(0, 3) == 0) drv_valid = '0;
            for (int i = 0; i < N; i++) begin
                drv_a[i] = rand_op();
                drv_b[i] = rand_op();
            end
            drv_rr = ($urandom_range(0, 9) < 7);
            run(1);
        end

        // Drain.
        drv_valid = '0; drv_rr = 1'b1;
        run(10);
        check("sb_empty", 64'(sb.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/fp_add_arbiter.md
Name: fp_add_arbiter

Overview:
- Shares one double-precision floating-point adder datapath (combinational, 64-bit IEEE-754 in, 64-bit out) among NUM_REQ requesters.
- Arbitrates with a round-robin policy and registers the winner's operands.
- Holds the operands stable for SETTLE_CYC cycles so the adder settles, then samples the result.
- Returns the sampled result on a valid/ready response channel tagged with the requester ID.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- ID_W, 2, requester ID width (must be ≥ clog2(NUM_REQ)).
- SETTLE_CYC, 2, cycles operands are held before the result is sampled (≥1).

Ports:
- clk  in  1  clock, rising-edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  NUM_REQ  per-requester request valid.
- req_ready  out  NUM_REQ  per-requester accept, one-hot or zero.
- req_a  in  64*NUM_REQ  operand A; requester i occupies bits [64i+63:64i].
- req_b  in  64*NUM_REQ  operand B, same packing as req_a.
- fpu_a  out  64  registered operand A to the adder.
- fpu_b  out  64  registered operand B to the adder.
- fpu_sum  in  64  adder result.
- resp_valid  out  1  response valid.
- resp_ready  in  1  response consumer ready.
- resp_id  out  ID_W  index of the requester that owns the response.
- resp_data  out  64  sampled sum.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (rst=1 at a clk edge): the following take effect on the next cycle.
  - State = IDLE.
  - rr_ptr = 0.
  - req_ready = 0, resp_valid = 0, busy = 0.
  - fpu_a = fpu_b = 0, resp_data = 0, resp_id = 0.
  - settle counter = 0.
  - An in-flight operation is discarded with no response.
- State IDLE:
  - req_ready is combinational: a one-hot grant to the first requester with req_valid=1, searching from rr_ptr upward with wrap at NUM_REQ-1 → 0.
  - If any req_valid is high: the handshake completes that cycle; fpu_a/fpu_b ← winner's operands, id ← winner, rr_ptr ← winner+1 (mod NUM_REQ), cnt ← SETTLE_CYC-1, next state = SETTLE.
  - No req_valid: stay in IDLE with req_ready = 0.
- State SETTLE:
  - req_ready = 0, fpu_a/fpu_b held stable.
  - While cnt != 0: cnt decrements each cycle.
  - When cnt == 0: resp_data ← fpu_sum, resp_id ← id, resp_valid ← 1, next state = RESP.
  - With SETTLE_CYC=1, SETTLE lasts exactly one cycle.
- State RESP:
  - resp_valid = 1; resp_data and resp_id stay stable until the handshake.
  - On resp_valid & resp_ready: resp_valid ← 0, next state = IDLE.
  - New requests are not accepted in RESP. The next grant comes no earlier than the cycle after the response handshake.
- Latency: accept at cycle T → resp_valid first high at T+SETTLE_CYC+1. Throughput is one operation per SETTLE_CYC+2 cycles when resp_ready is held at 1.
- Fairness: a continuously requesting requester is granted within NUM_REQ operations. Simultaneous requests are resolved solely by rr_ptr.
- A requester may drop req_valid before grant without penalty. Operands are sampled only in the grant cycle.
- Requester bits ≥ NUM_REQ do not exist; ID values ≥ NUM_REQ are never produced.
- busy = (state != IDLE).

Optional Feature:
- Macro FP_ADD_ARB_STATS_EN.
- Defined: adds output ports op_count (32-bit) and stall_count (32-bit).
  - op_count increments on each response handshake.
  - stall_count increments each cycle in RESP with resp_ready = 0.
  - Both counters wrap at 2^32, reset to 0 on rst.
- Undefined: these ports and counters are absent; all other behaviour is identical.

Test Plan:
- Single op, SETTLE_CYC=2:
  - Stimulus: req0 with a=0x3FF0000000000000, b=0x3FF0000000000000, resp_ready=1.
  - Response: resp_valid 3 cycles after accept; resp_data=0x4000000000000000 (2.0); resp_id=0.
- All four requesters valid continuously:
  - Grants occur in order 0,1,2,3,0.
  - Requester 2 with 1.5 + (-3.0) returns 0xBFF8000000000000 with resp_id=2.
- Backpressure:
  - Stimulus: hold resp_ready=0 for 5 cycles in RESP.
  - Response: resp_data/resp_id stable, req_ready=0 throughout; with STATS, stall_count=5 then op_count=1 after the handshake.
- Reset mid-operation:
  - Stimulus: assert rst during SETTLE.
  - Response: next cycle IDLE; resp_valid=0; rr_ptr=0; no response issued; the next request from req1 is served normally.
- Wrap and fairness:
  - Stimulus: rr_ptr=3 with req0 and req3 valid.
  - Response: req3 is granted first, then req0; rr_ptr then = 1.
- Early drop:
  - Stimulus: req1 raises and then drops req_valid while the arbiter is in RESP.
  - Response: req1 is never granted and no spurious response is issued.
